// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the iterative multiply/divide engine: operand width,
// iteration count, operation and state encodings, the divide-by-zero quotient
// and small helpers used when an operation is accepted.
// No ports (package).
// -----------------------------------------------------------------------------
package mult_div_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ITERATIONS = 32;

  // Counter value of the final RUN cycle.
  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } opT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } stateT;

  // Bit 1 of the encoding selects divide, bit 0 selects signed.
  function automatic logic isDivOp(input opT op);
    isDivOp = op[1];
  endfunction

  function automatic logic isSignedOp(input opT op);
    isSignedOp = op[0];
  endfunction

  // Unsigned magnitude of an operand, one bit wider so that |0x80000000|
  // is representable without special casing.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] value,
                                               input logic signedOp);
    if (signedOp && value[WIDTH-1]) begin
      magnitude = {(WIDTH+1){1'b0}} - {1'b1, value};
    end else begin
      magnitude = {1'b0, value};
    end
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// -----------------------------------------------------------------------------
// mult_div_if
// Start/busy/done handshake and operand/result bus between the execute stage
// (master) and the multiply/divide engine (slave).
//   Start, Op, A, B                          : master -> slave
//   Busy, Done, ResultHi, ResultLo, DivByZero: slave -> master
// -----------------------------------------------------------------------------
interface mult_div_if;
  import mult_div_pkg::*;

  logic             Start;
  opT               Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultHi;
  logic [WIDTH-1:0] ResultLo;
  logic             DivByZero;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, ResultHi, ResultLo, DivByZero
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, ResultHi, ResultLo, DivByZero
  );

endinterface

// File: rtl/mult_div_step.sv
// -----------------------------------------------------------------------------
// mult_div_step
// Combinational single-iteration datapath shared by multiply and divide.
//   isDiv   in  : 0 = shift-add multiply step, 1 = restoring divide step
//   hiIn    in  : partial sum (multiply) or partial remainder (divide)
//   loIn    in  : remaining multiplier bits (multiply) or dividend/quotient
//   operand in  : multiplicand magnitude (multiply) or divisor magnitude
//   hiOut   out : next hi word
//   loOut   out : next lo word
// Macro MULT_DIV_DIVIDER_EN compiles in the divide step; without it a divide
// iteration simply holds its state.
// -----------------------------------------------------------------------------
module mult_div_step
  import mult_div_pkg::*;
(
  input  logic             isDiv,
  input  logic [WIDTH-1:0] hiIn,
  input  logic [WIDTH-1:0] loIn,
  input  logic [WIDTH:0]   operand,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] partial;
`ifdef MULT_DIV_DIVIDER_EN
  logic [WIDTH:0] remShift;
`endif

  // One multiply or divide iteration on the current hi/lo pair.
  always_comb begin
    addend  = {(WIDTH+1){1'b0}};
    partial = {(WIDTH+1){1'b0}};
    hiOut   = hiIn;
    loOut   = loIn;
`ifdef MULT_DIV_DIVIDER_EN
    remShift = {hiIn, loIn[WIDTH-1]};
`endif
    if (!isDiv) begin
      // The carry of the add lands in partial[WIDTH] and is shifted into hi.
      if (loIn[0]) begin
        addend = operand;
      end else begin
        addend = {(WIDTH+1){1'b0}};
      end
      partial = {1'b0, hiIn} + addend;
      hiOut   = partial[WIDTH:1];
      loOut   = {partial[0], loIn[WIDTH-1:1]};
    end else begin
`ifdef MULT_DIV_DIVIDER_EN
      // Remainder stays below the divisor, so the difference fits in WIDTH bits.
      if (remShift >= operand) begin
        hiOut = remShift[WIDTH-1:0] - operand[WIDTH-1:0];
        loOut = {loIn[WIDTH-2:0], 1'b1};
      end else begin
        hiOut = remShift[WIDTH-1:0];
        loOut = {loIn[WIDTH-2:0], 1'b0};
      end
`else
      hiOut = hiIn;
      loOut = loIn;
`endif
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative 32-bit MULT/MULTU/DIV/DIVU engine feeding the HiLo unit. An
// accepted Start runs 32 RUN iterations, one FIXUP cycle for sign correction
// and result load, then a one-cycle DONE (Done pulse). Latency 34 cycles.
//   Clk   in    : rising-edge clock
//   Reset in    : synchronous active-high reset
//   bus   slave : Start/Op/A/B in; Busy/Done/ResultHi/ResultLo/DivByZero out
// Macro MULT_DIV_DIVIDER_EN: full divider compiled in. Without it, divides
// still take the full handshake and return Hi=0, Lo=0, DivByZero=1.
// -----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic     Clk,
  input  logic     Reset,
  mult_div_if.slave bus
);

  stateT            stateR;
  logic [4:0]       countR;
  logic             opDivR;
  logic             negR;        // product / quotient must be negated
  logic [WIDTH-1:0] hiR;
  logic [WIDTH-1:0] loR;
  logic [WIDTH:0]   operandR;
  logic             busyR;
  logic             doneR;
  logic [WIDTH-1:0] resHiR;
  logic [WIDTH-1:0] resLoR;
  logic             divByZeroR;
`ifdef MULT_DIV_DIVIDER_EN
  logic             negRemR;     // remainder follows the dividend sign
  logic [WIDTH-1:0] aOrigR;      // raw dividend, returned as Hi on B == 0
`endif

  logic             acceptS;
  logic             startSignedS;
  logic             startDivS;
  logic [WIDTH:0]   startMagAS;
  logic [WIDTH:0]   startMagBS;
  logic [WIDTH-1:0] initLoS;
  logic [WIDTH:0]   initOperandS;
  logic [WIDTH-1:0] stepHiS;
  logic [WIDTH-1:0] stepLoS;
  logic [2*WIDTH-1:0] productS;
  logic [WIDTH-1:0] fixupHiS;
  logic [WIDTH-1:0] fixupLoS;
  logic             fixupDbzS;

  assign bus.Busy      = busyR;
  assign bus.Done      = doneR;
  assign bus.ResultHi  = resHiR;
  assign bus.ResultLo  = resLoR;
  assign bus.DivByZero = divByZeroR;

  // Operand preparation for an accepted Start: multiply iterates over |B|
  // with |A| as addend, divide shifts |A| out against divisor |B|.
  always_comb begin
    acceptS      = ((stateR == ST_IDLE) || (stateR == ST_DONE)) && bus.Start;
    startSignedS = isSignedOp(bus.Op);
    startDivS    = isDivOp(bus.Op);
    startMagAS   = magnitude(bus.A, startSignedS);
    startMagBS   = magnitude(bus.B, startSignedS);
    if (startDivS) begin
      initLoS      = startMagAS[WIDTH-1:0];
      initOperandS = startMagBS;
    end else begin
      initLoS      = startMagBS[WIDTH-1:0];
      initOperandS = startMagAS;
    end
  end

  mult_div_step uStep (
    .isDiv   (opDivR),
    .hiIn    (hiR),
    .loIn    (loR),
    .operand (operandR),
    .hiOut   (stepHiS),
    .loOut   (stepLoS)
  );

  // Sign correction and special cases applied to the finished iteration state.
  always_comb begin
    productS  = {hiR, loR};
    fixupHiS  = {WIDTH{1'b0}};
    fixupLoS  = {WIDTH{1'b0}};
    fixupDbzS = 1'b0;
    if (!opDivR) begin
      if (negR) begin
        productS = 64'd0 - {hiR, loR};
      end else begin
        productS = {hiR, loR};
      end
      fixupHiS  = productS[2*WIDTH-1:WIDTH];
      fixupLoS  = productS[WIDTH-1:0];
      fixupDbzS = 1'b0;
    end else begin
`ifdef MULT_DIV_DIVIDER_EN
      // operandR holds |B| for divides, so zero here means B == 0.
      if (operandR == {(WIDTH+1){1'b0}}) begin
        fixupHiS  = aOrigR;
        fixupLoS  = DIV_ZERO_QUOTIENT;
        fixupDbzS = 1'b1;
      end else begin
        if (negR) begin
          fixupLoS = 32'd0 - loR;
        end else begin
          fixupLoS = loR;
        end
        if (negRemR) begin
          fixupHiS = 32'd0 - hiR;
        end else begin
          fixupHiS = hiR;
        end
        fixupDbzS = 1'b0;
      end
`else
      fixupHiS  = {WIDTH{1'b0}};
      fixupLoS  = {WIDTH{1'b0}};
      fixupDbzS = 1'b1;
`endif
    end
  end

  // Sequencing FSM, iteration counter, datapath registers and result outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateR     <= ST_IDLE;
      countR     <= 5'd0;
      opDivR     <= 1'b0;
      negR       <= 1'b0;
      hiR        <= {WIDTH{1'b0}};
      loR        <= {WIDTH{1'b0}};
      operandR   <= {(WIDTH+1){1'b0}};
      busyR      <= 1'b0;
      doneR      <= 1'b0;
      resHiR     <= {WIDTH{1'b0}};
      resLoR     <= {WIDTH{1'b0}};
      divByZeroR <= 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
      negRemR    <= 1'b0;
      aOrigR     <= {WIDTH{1'b0}};
`endif
    end else begin
      case (stateR)
        ST_IDLE, ST_DONE: begin
          doneR <= 1'b0;
          if (acceptS) begin
            stateR <= ST_RUN;
            busyR  <= 1'b1;
            countR <= 5'd0;
          end else begin
            stateR <= ST_IDLE;
            busyR  <= 1'b0;
          end
        end
        ST_RUN: begin
          hiR <= stepHiS;
          loR <= stepLoS;
          if (countR == LAST_ITER) begin
            stateR <= ST_FIXUP;
            countR <= 5'd0;
          end else begin
            countR <= countR + 5'd1;
          end
        end
        ST_FIXUP: begin
          stateR     <= ST_DONE;
          busyR      <= 1'b0;
          doneR      <= 1'b1;
          resHiR     <= fixupHiS;
          resLoR     <= fixupLoS;
          divByZeroR <= fixupDbzS;
        end
        default: begin
          stateR <= ST_IDLE;
          countR <= 5'd0;
          busyR  <= 1'b0;
          doneR  <= 1'b0;
        end
      endcase

      // Operands are captured only on the accepting edge.
      if (acceptS) begin
        hiR      <= {WIDTH{1'b0}};
        loR      <= initLoS;
        operandR <= initOperandS;
        opDivR   <= startDivS;
        negR     <= startSignedS & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
`ifdef MULT_DIV_DIVIDER_EN
        negRemR  <= startSignedS & bus.A[WIDTH-1];
        aOrigR   <= bus.A;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: table of directed operations with
// hand-computed results, plus sequences for back-to-back issue, Start while
// busy, reset mid-operation and reset colliding with Start.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
  import mult_div_pkg::*;

`ifdef MULT_DIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    opT          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDbz;
  } vecT;

  logic Clk;
  logic Reset;
  mult_div_if bus();

  mult_div_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] prevHi  = 32'd0;
  logic [31:0] prevLo  = 32'd0;
  logic        prevDbz = 1'b0;
  vecT vecs[10];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vecT mk(input opT op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
    vecT v;
    v.op = op; v.a = a; v.b = b;
    if (isDivOp(op) && !DIV_EN) begin
      v.expHi = 32'd0; v.expLo = 32'd0; v.expDbz = 1'b1;
    end else begin
      v.expHi = hi; v.expLo = lo; v.expDbz = dbz;
    end
    return v;
  endfunction

  // Called at a negative edge. Issues v, scrambles the inputs after the
  // accepting edge and checks Busy/Done every cycle up to the Done cycle.
  task automatic runOp(input string tag, input vecT v, input int pokeCycle);
    bus.Start = 1'b1; bus.Op = v.op; bus.A = v.a; bus.B = v.b;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    bus.Op = opT'(v.op ^ 2'b10);
    bus.A = 32'hDEAD_BEEF;
    bus.B = 32'h0000_0000;
    for (int i = 1; i <= 34; i++) begin
      @(negedge Clk);
      if (i == pokeCycle) begin
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.A = 32'd9; bus.B = 32'd3;
      end else begin
        bus.Start = 1'b0;
      end
      check($sformatf("%s_busy_c%0d", tag, i), 32'(bus.Busy), (i <= 33) ? 32'd1 : 32'd0);
      check($sformatf("%s_done_c%0d", tag, i), 32'(bus.Done), (i == 34) ? 32'd1 : 32'd0);
      if (i == 1 || i == 33) begin
        check($sformatf("%s_holdhi_c%0d", tag, i), bus.ResultHi, prevHi);
        check($sformatf("%s_holdlo_c%0d", tag, i), bus.ResultLo, prevLo);
        check($sformatf("%s_holddbz_c%0d", tag, i), 32'(bus.DivByZero), 32'(prevDbz));
      end
      if (i == 34) begin
        check($sformatf("%s_hi", tag), bus.ResultHi, v.expHi);
        check($sformatf("%s_lo", tag), bus.ResultLo, v.expLo);
        check($sformatf("%s_dbz", tag), 32'(bus.DivByZero), 32'(v.expDbz));
      end
    end
    prevHi = v.expHi; prevLo = v.expLo; prevDbz = v.expDbz;
  endtask

  // One idle cycle after an operation: the Done pulse must have ended.
  task automatic idleGap(input string tag);
    @(negedge Clk);
    check($sformatf("%s_gap_done", tag), 32'(bus.Done), 32'd0);
    check($sformatf("%s_gap_busy", tag), 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int doneCount;
    int busyCount;

    vecs[0] = mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    vecs[1] = mk(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    vecs[2] = mk(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    vecs[3] = mk(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    vecs[4] = mk(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    vecs[5] = mk(OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    vecs[6] = mk(OP_MULTU, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0);
    vecs[7] = mk(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    vecs[8] = mk(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    vecs[9] = mk(OP_MULT,  32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    Reset = 1'b1;
    bus.Start = 1'b0; bus.Op = OP_MULTU; bus.A = 32'd0; bus.B = 32'd0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_hi", bus.ResultHi, 32'd0);
    check("rst_lo", bus.ResultLo, 32'd0);
    check("rst_dbz", 32'(bus.DivByZero), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_busy", 32'(bus.Busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i], 0);
      idleGap($sformatf("vec%0d", i));
    end

    // Back-to-back: second Start is driven during the first Done cycle.
    runOp("b2b_a", mk(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0), 0);
    runOp("b2b_b", mk(OP_MULT, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0), 0);
    idleGap("b2b");

    // Start pulsed while busy must be ignored, and produce no second Done.
    runOp("poke", mk(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0), 5);
    doneCount = 0;
    busyCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (bus.Done) doneCount++;
      if (bus.Busy) busyCount++;
    end
    check("poke_extra_done", 32'(doneCount), 32'd0);
    check("poke_extra_busy", 32'(busyCount), 32'd0);

    // Reset at RUN cycle 10, with Start high on the same edge.
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(negedge Clk);
    check("midrst_busy_before", 32'(bus.Busy), 32'd1);
    Reset = 1'b1;
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    bus.Start = 1'b0;
    @(negedge Clk);
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_done", 32'(bus.Done), 32'd0);
    check("midrst_hi", bus.ResultHi, 32'd0);
    check("midrst_lo", bus.ResultLo, 32'd0);
    check("midrst_dbz", 32'(bus.DivByZero), 32'd0);
    doneCount = 0;
    busyCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (bus.Done) doneCount++;
      if (bus.Busy) busyCount++;
    end
    check("midrst_no_done", 32'(doneCount), 32'd0);
    check("midrst_no_busy", 32'(busyCount), 32'd0);
    prevHi = 32'd0; prevLo = 32'd0; prevDbz = 1'b0;

    runOp("recover", mk(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0), 0);
    idleGap("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
